dfr_readout_mac: RTL and testbench

Readout stage of the delayed-feedback reservoir. It consumes the serial stream of virtual-node states produced by the reservoir node chain and multiplies each state by a per-node trained weight. The products are accumulated over one full frame of NUM_NODES nodes, and the block emits one signed readout value per frame over a valid/ready handshake. Weights live in an internal register file that software writes.

---
 rtl/dfr_pkg.sv | 15 +
 rtl/dfr_weight_rf.sv | 28 ++
 rtl/dfr_readout_mac.sv | 107 ++++++++++
 tb/tb_dfr_readout_mac.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dfr_pkg.sv
// Shared types and helpers for the delayed-feedback reservoir readout.
package dfr_pkg;

    typedef enum logic [1:0] {
        ACC,
        FLUSH,
        HOLD
    } readout_state_t;

    // Accumulator width that cannot overflow when summing num_nodes full products.
    function automatic int acc_width(input int data_width, input int num_nodes);
        return 2 * data_width + $clog2(num_nodes);
    endfunction

endpackage

// File: rtl/dfr_weight_rf.sv
// Per-node readout weight store: synchronous write, asynchronous read, cleared on reset.
module dfr_weight_rf #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODES  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_NODES)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [$clog2(NUM_NODES)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data
);

    logic [NUM_NODES-1:0][DATA_WIDTH-1:0] mem;

    // Reads see the pre-edge contents, so a same-edge read and write returns the old weight.
    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/dfr_readout_mac.sv
// Reservoir readout: multiplies each streamed node state by its weight and emits one frame sum.
module dfr_readout_mac
    import dfr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODES  = 16,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, NUM_NODES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         weight_wr_en,
    input  logic [$clog2(NUM_NODES)-1:0] weight_wr_addr,
    input  logic [DATA_WIDTH-1:0]        weight_wr_data,
    input  logic                         node_valid,
    input  logic [DATA_WIDTH-1:0]        node_data,
    output logic                         node_ready,
    output logic                         out_valid,
    output logic [ACC_WIDTH-1:0]         out_data,
    input  logic                         out_ready,
    output logic [$clog2(NUM_NODES)-1:0] node_idx
);

    localparam int IDX_W  = $clog2(NUM_NODES);
    localparam int PROD_W = 2 * DATA_WIDTH;

    readout_state_t state, state_nxt;

    logic [DATA_WIDTH-1:0]       weight_rd;
    logic signed [PROD_W-1:0]    prod;
    logic signed [PROD_W-1:0]    prod_reg;
    logic                        prod_vld;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic                        accept;
    logic                        last;

    dfr_weight_rf #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_NODES  (NUM_NODES)
    ) u_weight_rf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (weight_wr_en),
        .wr_addr (weight_wr_addr),
        .wr_data (weight_wr_data),
        .rd_addr (node_idx),
        .rd_data (weight_rd)
    );

    assign node_ready = (state == ACC);
    assign out_valid  = (state == HOLD);
    assign out_data   = acc;
    assign accept     = node_valid && node_ready;
    assign last       = (node_idx == IDX_W'(NUM_NODES - 1));
    assign prod       = $signed(node_data) * $signed(weight_rd);
    assign prod_ext   = ACC_WIDTH'(prod_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (accept && last) state_nxt = FLUSH;
            FLUSH:   state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    // One-deep product pipeline: the product of node k is accumulated while node k+1 multiplies.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            prod_reg <= '0;
            prod_vld <= 1'b0;
            node_idx <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (prod_vld) acc <= acc + prod_ext;
                    if (accept) begin
                        prod_reg <= prod;
                        prod_vld <= 1'b1;
                        node_idx <= last ? '0 : node_idx + IDX_W'(1);
                    end else begin
                        prod_vld <= 1'b0;
                    end
                end
                FLUSH: begin
                    acc      <= acc + prod_ext;
                    prod_vld <= 1'b0;
                end
                HOLD: begin
                    if (out_ready) acc <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dfr_readout_mac.sv
// Self-checking bench for dfr_readout_mac with DATA_WIDTH=16, NUM_NODES=4.
module tb_dfr_readout_mac;

    localparam int DW = 16;
    localparam int NN = 4;
    localparam int AW = 34;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          weight_wr_en = 1'b0;
    logic [1:0]    weight_wr_addr = '0;
    logic [DW-1:0] weight_wr_data = '0;
    logic          node_valid = 1'b0;
    logic [DW-1:0] node_data = '0;
    logic          node_ready;
    logic          out_valid;
    logic [AW-1:0] out_data;
    logic          out_ready = 1'b1;
    logic [1:0]    node_idx;

    dfr_readout_mac #(.DATA_WIDTH(DW), .NUM_NODES(NN)) dut (
        .clk            (clk),
        .rst            (rst),
        .weight_wr_en   (weight_wr_en),
        .weight_wr_addr (weight_wr_addr),
        .weight_wr_data (weight_wr_data),
        .node_valid     (node_valid),
        .node_data      (node_data),
        .node_ready     (node_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .node_idx       (node_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NN-1:0][DW-1:0] w;
        logic [NN-1:0][DW-1:0] n;
        logic [AW-1:0]         exp;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] sb_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are driven at the negedge; a handshake seen here happens on the coming posedge.
    task automatic cyc();
        logic [AW-1:0] e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 64'(out_data), 64'hDEAD);
            end else begin
                e = sb_q.pop_front();
                chk("sb_out_data", 64'(out_data), 64'(e));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_w(input logic [1:0] a, input logic [DW-1:0] d);
        weight_wr_en   = 1'b1;
        weight_wr_addr = a;
        weight_wr_data = d;
        cyc();
        weight_wr_en   = 1'b0;
    endtask

    task automatic send_node(input logic [DW-1:0] d);
        int b = 0;
        node_valid = 1'b1;
        node_data  = d;
        while (!node_ready && b < 20) begin
            cyc();
            b++;
        end
        if (!node_ready) chk("node_ready_timeout", 64'(node_ready), 64'd1);
        cyc();
        node_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [NN-1:0][DW-1:0] n);
        for (int i = 0; i < NN; i++) begin
            chk("node_idx_seq", 64'(node_idx), 64'(i));
            send_node(n[i]);
        end
    endtask

    task automatic drain();
        int b = 0;
        while (sb_q.size() != 0 && b < 30) begin
            cyc();
            b++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    vec_t vecs[3];

    initial begin
        vecs[0].w = {16'sd4, 16'sd3, 16'sd2, 16'sd1};
        vecs[0].n = {16'sd40, 16'sd30, 16'sd20, 16'sd10};
        vecs[0].exp = 34'd300;
        vecs[1].w = {16'sd4, -16'sd3, 16'sd2, -16'sd1};
        vecs[1].n = {-16'sd2, 16'sd9, 16'sd7, -16'sd5};
        vecs[1].exp = 34'h3FFFFFFF0;            // 5 + 14 - 27 - 8 = -16
        vecs[2].w = {4{16'h8000}};
        vecs[2].n = {4{16'h8000}};
        vecs[2].exp = 34'h100000000;            // 4 * 2^30

        @(negedge clk);
        cyc();
        rst = 1'b0;
        chk("rst_node_ready", 64'(node_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_node_idx", 64'(node_idx), 64'd0);

        // Table: back-to-back frames with out_ready held high, latency and frame period checked.
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < NN; i++) write_w(2'(i), vecs[v].w[i]);
            sb_q.push_back(vecs[v].exp);
            send_frame(vecs[v].n);
            chk("flush_out_valid", 64'(out_valid), 64'd0);
            chk("flush_node_ready", 64'(node_ready), 64'd0);
            cyc();
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_node_ready", 64'(node_ready), 64'd0);
            chk("hold_out_data", 64'(out_data), 64'(vecs[v].exp));
            cyc();
            chk("post_out_valid", 64'(out_valid), 64'd0);
            chk("post_node_ready", 64'(node_ready), 64'd1);
            chk("post_out_data", 64'(out_data), 64'd0);
            chk("sb_empty", 64'(sb_q.size()), 64'd0);
        end

        // Backpressure: HOLD is stable and blocks nodes while out_ready is low.
        for (int i = 0; i < NN; i++) write_w(2'(i), vecs[0].w[i]);
        out_ready = 1'b0;
        sb_q.push_back(34'd300);
        send_frame(vecs[0].n);
        cyc();
        node_valid = 1'b1;
        node_data  = 16'sd5;
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_node_ready", 64'(node_ready), 64'd0);
            chk("bp_out_data", 64'(out_data), 64'd300);
            chk("bp_node_idx", 64'(node_idx), 64'd0);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_release_data", 64'(out_data), 64'd0);
        chk("bp_release_ready", 64'(node_ready), 64'd1);
        cyc();
        chk("bp_immediate_accept", 64'(node_idx), 64'd1);

        // Reset mid-frame discards the partial sum and clears weights.
        cyc();
        node_valid = 1'b0;
        chk("mid_node_idx", 64'(node_idx), 64'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_node_idx", 64'(node_idx), 64'd0);
        chk("mrst_out_data", 64'(out_data), 64'd0);
        chk("mrst_node_ready", 64'(node_ready), 64'd1);
        sb_q.push_back(34'd0);                  // weights were cleared by reset
        send_frame({16'sd4, 16'sd3, 16'sd2, 16'sd1});
        drain();
        for (int i = 0; i < NN; i++) write_w(2'(i), 16'sd1);
        sb_q.push_back(34'd10);
        send_frame({16'sd4, 16'sd3, 16'sd2, 16'sd1});
        drain();

        // Same-edge write and accept at index 0: old weight used now, new one next frame.
        sb_q.push_back(34'd1);
        node_valid     = 1'b1;
        node_data      = 16'sd1;
        weight_wr_en   = 1'b1;
        weight_wr_addr = 2'd0;
        weight_wr_data = 16'sd100;
        chk("rbw_node_ready", 64'(node_ready), 64'd1);
        cyc();
        weight_wr_en = 1'b0;
        for (int i = 1; i < NN; i++) send_node(16'sd0);
        drain();
        sb_q.push_back(34'd100);
        send_frame({16'sd0, 16'sd0, 16'sd0, 16'sd1});
        drain();
        for (int k = 0; k < 3; k++) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
